adc_frame_scheduler: RTL and testbench

Sequences MCP3002 conversions at a fixed sampling rate and assembles the returned samples into FRAME_LEN-sample frames in an internal ping-pong buffer. Completed frames are handed to the demodulation datapath (FFT/symbol decoder) through a valid/ack handshake and a random-access read port. The block sits between the MCP3002 SPI driver and the demodulator inside `top`. It replaces ad-hoc free-running sampling with explicit overrun and missed-sample reporting.

---
 rtl/adc_frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// Paces MCP3002 conversions and packs samples into ping-pong frames
// handed to the demodulator via a valid/ack handshake and a read port.
module adc_frame_scheduler #(
  parameter int CLK_FREQ          = 48_000_000,
  parameter int ADC_SAMPLING_FREQ = 48_000,
  parameter int FRAME_LEN         = 1024,
  parameter int ADC_BITS          = 10,
  parameter int ADDR_W            = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic                frame_valid,
  output logic                frame_bank,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [ADC_BITS-1:0] rd_data,
  input  logic                frame_ack,
  output logic                overrun,
  output logic                sample_missed,
  output logic [15:0]         drop_count
);

  localparam int SAMPLE_CYCLE = CLK_FREQ / ADC_SAMPLING_FREQ;
  localparam int CW = $clog2(SAMPLE_CYCLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_CYCLE - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CONV,
    S_WRITE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                en_q;
  logic                start_q, start_d;
  logic [ADC_BITS-1:0] sample_q, sample_d;
  logic                abort_q, abort_d;
  logic [1:0]          full_q, full_d;
  logic                wb_q, wb_d;
  logic                pb_q, pb_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ovr_q, ovr_d;
  logic                miss_q, miss_d;
  logic [15:0]         drop_q, drop_d;
  logic [ADC_BITS-1:0] rd_q;
  logic                tick, fall, wr_go, we;

  logic [ADC_BITS-1:0] mem_q [2*FRAME_LEN];

  always_comb begin
    tick     = enable && (cnt_q == CNT_MAX);
    fall     = en_q && !enable;
    cnt_d    = (!enable || tick) ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    start_d  = 1'b0;
    sample_d = sample_q;
    abort_d  = abort_q;
    full_d   = full_q;
    wb_d     = wb_q;
    pb_d     = pb_q;
    ptr_d    = ptr_q;
    ovr_d    = ovr_q;
    miss_d   = miss_q;
    drop_d   = drop_q;
    wr_go    = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          start_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (tick) miss_d = 1'b1;
        if (!enable) abort_d = 1'b1;
        // A conversion that saw enable drop is drained but never stored
        if (adc_done) begin
          sample_d = adc_data;
          abort_d  = 1'b0;
          state_d  = (abort_q || !enable) ? S_IDLE : S_WRITE;
        end
      end
      S_WRITE: begin
        wr_go   = enable;
        state_d = enable ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_go) begin
      if (!full_q[wb_q]) begin
        we = 1'b1;
        if (ptr_q == PTR_MAX) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
          ptr_d        = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        ovr_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
    if (fall) ptr_d = '0;

    // Completion and ack always target different banks
    if (frame_ack && full_q[pb_q]) begin
      full_d[pb_q] = 1'b0;
      pb_d         = ~pb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      sample_q <= '0;
      abort_q  <= 1'b0;
      full_q   <= '0;
      wb_q     <= 1'b0;
      pb_q     <= 1'b0;
      ptr_q    <= '0;
      ovr_q    <= 1'b0;
      miss_q   <= 1'b0;
      drop_q   <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= enable;
      start_q  <= start_d;
      sample_q <= sample_d;
      abort_q  <= abort_d;
      full_q   <= full_d;
      wb_q     <= wb_d;
      pb_q     <= pb_d;
      ptr_q    <= ptr_d;
      ovr_q    <= ovr_d;
      miss_q   <= miss_d;
      drop_q   <= drop_d;
      rd_q     <= mem_q[{pb_q, rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[{wb_q, ptr_q}] <= sample_q;
  end

  assign adc_start     = start_q;
  assign frame_valid   = full_q[pb_q];
  assign frame_bank    = pb_q;
  assign rd_data       = rd_q;
  assign overrun       = ovr_q;
  assign sample_missed = miss_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Scenario bench for adc_frame_scheduler: driver model answers
// adc_start, stored samples are queued and checked on readback.
module tb_adc_frame_scheduler;

  localparam int AB = 10;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          adc_start;
  logic          adc_done;
  logic [AB-1:0] adc_data;
  logic          frame_valid;
  logic          frame_bank;
  logic [AW-1:0] rd_addr;
  logic [AB-1:0] rd_data;
  logic          frame_ack;
  logic          overrun;
  logic          sample_missed;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AB-1:0] sb [$];

  adc_frame_scheduler #(
    .CLK_FREQ(48_000_000),
    .ADC_SAMPLING_FREQ(600_000),
    .FRAME_LEN(8),
    .ADC_BITS(AB),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_start(adc_start),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .frame_valid(frame_valid),
    .frame_bank(frame_bank),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_ack(frame_ack),
    .overrun(overrun),
    .sample_missed(sample_missed),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    adc_done = 1'b0;
    adc_data = '0;
    frame_ack = 1'b0;
    rd_addr = '0;
    step(2);
    rst = 1'b0;
  endtask

  // Driver model: wait for adc_start, answer dly cycles later
  task automatic feed(input logic [AB-1:0] v, input int dly,
                      output int t0);
    int n;
    n = 0;
    t0 = -1;
    while (n < 400) begin
      step(1);
      n++;
      if (adc_start === 1'b1) begin
        t0 = cyc;
        break;
      end
    end
    checks++;
    if (t0 < 0) begin
      errors++;
      $display("FAIL start_timeout: no adc_start in %0d cycles, required 1", n);
      return;
    end
    step(dly);
    adc_done = 1'b1;
    adc_data = v;
    step(1);
    adc_done = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({adc_start, frame_valid, frame_bank, overrun, sample_missed} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {adc_start, frame_valid, frame_bank, overrun, sample_missed});
    end
    checks++;
    if (drop_count !== 16'd0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: drop=%0d rd=%0d, required 0 0", drop_count, rd_data);
    end
  endtask

  task automatic test_rate();
    int ts [5];
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) feed(AB'(i), 30, ts[i]);
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (ts[i] - ts[i-1] !== 80) begin
        errors++;
        $display("FAIL rate_period%0d: got %0d, required 80", i, ts[i] - ts[i-1]);
      end
    end
    checks++;
    if (sample_missed !== 1'b0) begin
      errors++;
      $display("FAIL rate_missed: got %b, required 0", sample_missed);
    end
  endtask

  task automatic test_frame_fill();
    int t;
    logic [AB-1:0] e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      feed(AB'(i), 30, t);
      sb.push_back(AB'(i));
    end
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_early_valid: got %b, required 0", frame_valid);
    end
    step(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin
      errors++;
      $display("FAIL fill_valid: valid=%b bank=%b, required 1 0", frame_valid, frame_bank);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      step(1);
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL fill_rd%0d: got %0d, required %0d", a, rd_data, e);
      end
    end
  endtask

  task automatic test_ping_pong();
    int t;
    logic [AB-1:0] e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      feed(AB'(i), 30, t);
      sb.push_back(AB'(i));
      if (i == 7) begin
        step(1);
        for (int a = 0; a < 8; a++) begin
          rd_addr = AW'(a);
          step(1);
          e = sb.size() > 0 ? sb.pop_front() : 'x;
          checks++;
          if (rd_data !== e) begin
            errors++;
            $display("FAIL pp_bank0_rd%0d: got %0d, required %0d", a, rd_data, e);
          end
        end
      end
      if (i == 10) begin
        step(1);
        ack();
        checks++;
        if (frame_valid !== 1'b0 || frame_bank !== 1'b1) begin
          errors++;
          $display("FAIL pp_after_ack: valid=%b bank=%b, required 0 1",
                   frame_valid, frame_bank);
        end
      end
    end
    step(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL pp_second: valid=%b bank=%b ovr=%b, required 1 1 0",
               frame_valid, frame_bank, overrun);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      step(1);
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL pp_bank1_rd%0d: got %0d, required %0d", a, rd_data, e);
      end
    end
  endtask

  task automatic test_overrun();
    int t;
    logic [AB-1:0] e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      feed(AB'(i), 30, t);
      if (i < 16) sb.push_back(AB'(i));
    end
    step(1);
    checks++;
    if (overrun !== 1'b1 || drop_count !== 16'd4) begin
      errors++;
      $display("FAIL ovr_flags: ovr=%b drop=%0d, required 1 4", overrun, drop_count);
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin
      errors++;
      $display("FAIL ovr_present: valid=%b bank=%b, required 1 0", frame_valid, frame_bank);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      step(1);
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL ovr_bank0_rd%0d: got %0d, required %0d", a, rd_data, e);
      end
    end
    ack();
    checks++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1) begin
      errors++;
      $display("FAIL ovr_ack_toggle: valid=%b bank=%b, required 1 1", frame_valid, frame_bank);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      step(1);
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL ovr_bank1_rd%0d: got %0d, required %0d", a, rd_data, e);
      end
    end
    feed(10'd100, 30, t);
    sb.push_back(10'd100);
    step(1);
    checks++;
    if (drop_count !== 16'd4) begin
      errors++;
      $display("FAIL ovr_drop_hold: got %0d, required 4", drop_count);
    end
    ack();
    checks++;
    if (frame_valid !== 1'b0 || frame_bank !== 1'b0) begin
      errors++;
      $display("FAIL ovr_second_ack: valid=%b bank=%b, required 0 0", frame_valid, frame_bank);
    end
    rd_addr = '0;
    step(1);
    e = sb.size() > 0 ? sb.pop_front() : 'x;
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL ovr_refill: got %0d, required %0d", rd_data, e);
    end
  endtask

  task automatic test_missed();
    int n;
    int pulses;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (n < 400 && adc_start !== 1'b1) begin
      step(1);
      n++;
    end
    checks++;
    if (adc_start !== 1'b1) begin
      errors++;
      $display("FAIL miss_start_timeout: got %b, required 1", adc_start);
    end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (adc_start === 1'b1) pulses++;
      if (i == 40) begin
        checks++;
        if (sample_missed !== 1'b0) begin
          errors++;
          $display("FAIL miss_early: got %b, required 0", sample_missed);
        end
      end
    end
    checks++;
    if (pulses !== 0 || sample_missed !== 1'b1) begin
      errors++;
      $display("FAIL miss_flag: pulses=%0d missed=%b, required 0 1", pulses, sample_missed);
    end
    adc_done = 1'b1;
    adc_data = 10'd9;
    step(1);
    adc_done = 1'b0;
  endtask

  task automatic test_reset_enable();
    int n;
    int t;
    int pulses;
    logic [AB-1:0] e;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (n < 400 && adc_start !== 1'b1) begin
      step(1);
      n++;
    end
    step(10);
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);
    adc_done = 1'b1;
    adc_data = 10'd55;
    pulses = 0;
    step(1);
    adc_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (adc_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || frame_valid !== 1'b0 || overrun !== 1'b0 ||
        sample_missed !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_late_done: start=%0d valid=%b ovr=%b miss=%b drop=%0d, required all 0",
               pulses, frame_valid, overrun, sample_missed, drop_count);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) feed(AB'(200 + i), 30, t);
    step(1);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      feed(AB'(10 + i), 30, t);
      sb.push_back(AB'(10 + i));
      if (i == 6) begin
        step(1);
        checks++;
        if (frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL en_partial: got %b, required 0", frame_valid);
        end
      end
    end
    step(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b0) begin
      errors++;
      $display("FAIL en_frame: valid=%b bank=%b, required 1 0", frame_valid, frame_bank);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      step(1);
      e = sb.size() > 0 ? sb.pop_front() : 'x;
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL en_rd%0d: got %0d, required %0d", a, rd_data, e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rate();
    test_frame_fill();
    test_ping_pong();
    test_overrun();
    test_missed();
    test_reset_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
